// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache, one 32-bit word
// per line. Hits answer combinationally in the same cycle; misses run a
// single-word fill over the crossbar read port and answer from fill_data in
// RESP. A one-cycle flush drops every valid bit.
module icache_direct #(
  parameter int          INDEX_BITS = 6,
  parameter logic [31:0] CACHE_BASE = 32'h8000_0000,
  parameter logic [31:0] CACHE_MASK = 32'hFFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  input  logic        mem_ok,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state;
  logic [31:0]           fill_addr;
  logic [31:0]           fill_data;
  logic                  settle;
  logic                  no_alloc;

  logic [LINES-1:0]      valid;
  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [31:0]           data_mem [LINES];

  logic [INDEX_BITS-1:0] cpu_idx;
  logic [TAG_W-1:0]      cpu_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic                  cpu_cacheable;
  logic                  fill_cacheable;
  logic                  hit;
  logic                  start_miss;
  logic                  alloc;

  assign cpu_idx        = cpu_addr[INDEX_BITS+1:2];
  assign cpu_tag        = cpu_addr[31:INDEX_BITS+2];
  assign fill_idx       = fill_addr[INDEX_BITS+1:2];
  assign fill_tag       = fill_addr[31:INDEX_BITS+2];
  assign cpu_cacheable  = (cpu_addr  & CACHE_MASK) == CACHE_BASE;
  assign fill_cacheable = (fill_addr & CACHE_MASK) == CACHE_BASE;

  // A flush in flight hides every line, so a request under flush becomes a miss.
  assign hit = cpu_req && (state == IDLE) && !flush && cpu_cacheable &&
               valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);

  assign start_miss = cpu_req && (state == IDLE) && !hit;

  // Allocation happens on the RESP edge; a flush anywhere during the miss
  // (sticky no_alloc, or flush in RESP itself) cancels it.
  assign alloc = (state == RESP) && fill_cacheable && !no_alloc && !flush;

  // CPU response: hit data in IDLE, captured fill data in RESP, zero otherwise.
  always_comb begin
    cpu_ready = 1'b0;
    cpu_rdata = 32'h0;
    if (hit) begin
      cpu_ready = 1'b1;
      cpu_rdata = data_mem[cpu_idx];
    end else if (state == RESP) begin
      cpu_ready = 1'b1;
      cpu_rdata = fill_data;
    end
  end

  // Crossbar request: address held stable for the whole FILL state.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = 32'h0;
    if (state == FILL) begin
      mem_req  = 1'b1;
      mem_addr = fill_addr;
    end
  end

  // Miss FSM: IDLE -> FILL -> RESP -> IDLE, with the settle handshake in FILL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fill_addr <= 32'h0;
      fill_data <= 32'h0;
      settle    <= 1'b0;
      no_alloc  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          no_alloc <= 1'b0;
          if (start_miss) begin
            fill_addr <= cpu_addr & 32'hFFFF_FFFC;
            settle    <= 1'b0;
            state     <= FILL;
          end
        end
        FILL: begin
          if (flush) no_alloc <= 1'b1;
          // The crossbar registers the address, so mem_din is only trusted
          // after a full cycle of mem_ok; any stall restarts that count.
          if (!mem_ok) begin
            settle <= 1'b0;
          end else if (!settle) begin
            settle <= 1'b1;
          end else begin
            fill_data <= mem_din;
            settle    <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          no_alloc <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          no_alloc <= 1'b0;
          settle   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Valid bits: reset and flush clear all; a completed cacheable miss sets one.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= '0;
    end else if (alloc) begin
      valid[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (!rst && alloc) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= fill_data;
    end
  end

  // Debug counters: saturate at all-ones, survive flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (hit && (hit_count != 32'hFFFF_FFFF))
        hit_count <= hit_count + 32'd1;
      if (start_miss && (miss_count != 32'hFFFF_FFFF))
        miss_count <= miss_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed checks of hit/miss timing, stalled fills,
// conflict eviction, uncached fetches, flush and mid-fill reset.
module tb_icache_direct;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_ok;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  icache_direct dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_ok     (mem_ok),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge; inputs are then driven and
  // outputs sampled a further #1 later, well before the falling edge.
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Standard miss: request cycle, two FILL cycles with mem_ok=1, RESP.
  task automatic miss(input string tag, input logic [31:0] addr, input logic [31:0] data);
    cpu_req = 1'b1; cpu_addr = addr; mem_ok = 1'b1; mem_din = JUNK;
    #1;
    chk({tag, ".req_ready"}, {31'h0, cpu_ready}, 32'h0);
    cyc; #1;
    chk({tag, ".fill_req"},  {31'h0, mem_req},   32'h1);
    chk({tag, ".fill_addr"}, mem_addr,           addr & 32'hFFFF_FFFC);
    chk({tag, ".fill1_rdy"}, {31'h0, cpu_ready}, 32'h0);
    cyc; mem_din = data; #1;
    chk({tag, ".fill2_rdy"}, {31'h0, cpu_ready}, 32'h0);
    cyc; mem_din = JUNK; #1;
    chk({tag, ".resp_rdy"},  {31'h0, cpu_ready}, 32'h1);
    chk({tag, ".resp_data"}, cpu_rdata,          data);
    chk({tag, ".resp_mreq"}, {31'h0, mem_req},   32'h0);
    cyc; cpu_req = 1'b0; #1;
  endtask

  task automatic hit(input string tag, input logic [31:0] addr, input logic [31:0] data);
    cpu_req = 1'b1; cpu_addr = addr;
    #1;
    chk({tag, ".hit_rdy"},  {31'h0, cpu_ready}, 32'h1);
    chk({tag, ".hit_data"}, cpu_rdata,          data);
    chk({tag, ".hit_mreq"}, {31'h0, mem_req},   32'h0);
    cyc; cpu_req = 1'b0; #1;
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = 32'h0; flush = 1'b0;
    mem_din = 32'h0; mem_ok = 1'b0;
    cyc; cyc; rst = 1'b0; #1;

    // Reset state
    chk("rst.ready",  {31'h0, cpu_ready}, 32'h0);
    chk("rst.rdata",  cpu_rdata,          32'h0);
    chk("rst.mreq",   {31'h0, mem_req},   32'h0);
    chk("rst.maddr",  mem_addr,           32'h0);
    chk("rst.hits",   hit_count,          32'h0);
    chk("rst.misses", miss_count,         32'h0);

    // 1. Cold miss then same-cycle hit
    miss("t1", 32'h8000_0010, 32'h2402_0005);
    hit("t1", 32'h8000_0010, 32'h2402_0005);
    chk("t1.hits",   hit_count,  32'd1);
    chk("t1.misses", miss_count, 32'd1);

    // 2. Stalled fill: mem_ok 1,0,0,1,1 -> capture on the fifth FILL cycle
    cpu_req = 1'b1; cpu_addr = 32'h8000_0040; mem_ok = 1'b1; mem_din = JUNK; #1;
    chk("t2.req_ready", {31'h0, cpu_ready}, 32'h0);
    cyc; #1;
    chk("t2.f1_mreq", {31'h0, mem_req}, 32'h1);
    cyc; mem_ok = 1'b0; mem_din = 32'hBAD0_0002; #1;
    chk("t2.f2_rdy", {31'h0, cpu_ready}, 32'h0);
    cyc; #1;
    chk("t2.f3_rdy", {31'h0, cpu_ready}, 32'h0);
    cyc; mem_ok = 1'b1; mem_din = 32'hBAD0_0004; #1;
    chk("t2.f4_rdy", {31'h0, cpu_ready}, 32'h0);
    cyc; mem_din = 32'h1111_2222; #1;
    chk("t2.f5_rdy",  {31'h0, cpu_ready}, 32'h0);
    chk("t2.f5_mreq", {31'h0, mem_req},   32'h1);
    chk("t2.f5_addr", mem_addr,           32'h8000_0040);
    cyc; mem_din = JUNK; #1;
    chk("t2.resp_rdy",  {31'h0, cpu_ready}, 32'h1);
    chk("t2.resp_data", cpu_rdata,          32'h1111_2222);
    cyc; cpu_req = 1'b0; #1;
    hit("t2", 32'h8000_0040, 32'h1111_2222);
    chk("t2.hits",   hit_count,  32'd2);
    chk("t2.misses", miss_count, 32'd2);

    // 3. Conflict eviction on index 1
    miss("t3a", 32'h8000_0004, 32'hAAAA_0001);
    miss("t3b", 32'h8000_0104, 32'hBBBB_0002);
    miss("t3c", 32'h8000_0004, 32'hAAAA_0003);
    chk("t3.misses", miss_count, 32'd5);
    hit("t3", 32'h8000_0004, 32'hAAAA_0003);

    // 4. Uncached address never allocates
    miss("t4a", 32'hBFC0_0000, 32'h3C08_BFC0);
    miss("t4b", 32'hBFC0_0000, 32'h3C08_BFC1);
    chk("t4.hits",   hit_count,  32'd3);
    chk("t4.misses", miss_count, 32'd7);

    // 5a. Flush in the same cycle as a request to a valid line -> miss
    miss("t5a", 32'h8000_0020, 32'hC000_0001);
    cpu_req = 1'b1; cpu_addr = 32'h8000_0020; flush = 1'b1; mem_ok = 1'b1; #1;
    chk("t5b.req_ready", {31'h0, cpu_ready}, 32'h0);
    cyc; flush = 1'b0; #1;
    chk("t5b.fill_req", {31'h0, mem_req}, 32'h1);
    cyc; mem_din = 32'hC000_0002; #1;
    cyc; mem_din = JUNK; #1;
    chk("t5b.resp_data", cpu_rdata, 32'hC000_0002);
    cyc; cpu_req = 1'b0; #1;
    hit("t5b", 32'h8000_0020, 32'hC000_0002);

    // 5b. Flush pulse alone, then refetch misses
    flush = 1'b1; cyc; flush = 1'b0; #1;
    miss("t5c", 32'h8000_0020, 32'hC000_0003);

    // 5c. Flush during FILL: data returned, no allocation
    cpu_req = 1'b1; cpu_addr = 32'h8000_0030; mem_ok = 1'b1; mem_din = JUNK; #1;
    cyc; flush = 1'b1; #1;
    chk("t5d.fill_req", {31'h0, mem_req}, 32'h1);
    cyc; flush = 1'b0; mem_din = 32'hD000_0001; #1;
    cyc; mem_din = JUNK; #1;
    chk("t5d.resp_rdy",  {31'h0, cpu_ready}, 32'h1);
    chk("t5d.resp_data", cpu_rdata,          32'hD000_0001);
    cyc; cpu_req = 1'b0; #1;
    miss("t5e", 32'h8000_0030, 32'hD000_0002);
    chk("t5.hits",   hit_count,  32'd4);
    chk("t5.misses", miss_count, 32'd12);

    // 6. Reset in the middle of a fill
    cpu_req = 1'b1; cpu_addr = 32'h8000_0050; mem_ok = 1'b1; mem_din = JUNK; #1;
    cyc; #1;
    chk("t6.fill_req", {31'h0, mem_req}, 32'h1);
    rst = 1'b1;
    cyc; rst = 1'b0; cpu_req = 1'b0; #1;
    chk("t6.mreq",   {31'h0, mem_req},   32'h0);
    chk("t6.ready",  {31'h0, cpu_ready}, 32'h0);
    chk("t6.hits",   hit_count,          32'h0);
    chk("t6.misses", miss_count,         32'h0);
    cyc; #1;
    chk("t6.idle_mreq", {31'h0, mem_req}, 32'h0);
    miss("t6a", 32'h8000_0010, 32'h2402_0006);
    miss("t6b", 32'h8000_0040, 32'h1111_3333);
    chk("t6.misses_after", miss_count, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch stage and the crossbar's instruction read port (sram_interface.master_r side).
- Hits return an instruction word in the same cycle.
- Misses run a single-word fill over the crossbar read port. The fill tolerates the port's stall (ok low) while the data side holds base RAM.
- Supports a one-cycle full invalidate for self-modifying code loaded by the monitor.

Parameters:
- INDEX_BITS, 6, log2 of line count; one 32-bit word per line (64 lines default).
- CACHE_BASE, 32'h8000_0000, lowest cacheable address.
- CACHE_MASK, 32'hFFC0_0000, an address is cacheable iff (addr & CACHE_MASK) == CACHE_BASE.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_req  in  1  fetch request; held with cpu_addr stable until cpu_ready
- cpu_addr  in  32  fetch address; bits [1:0] ignored
- cpu_rdata  out  32  instruction word; valid only while cpu_ready=1
- cpu_ready  out  1  fetch complete this cycle
- flush  in  1  invalidate all lines
- mem_req  out  1  to crossbar icache.req
- mem_addr  out  32  to crossbar icache.addr
- mem_din  in  32  from crossbar icache.din
- mem_ok  in  1  from crossbar icache.ok
- hit_count  out  32  saturating hit counter (debug)
- miss_count  out  32  saturating miss counter (debug)

Behaviour:
- Address split: offset [1:0]; index [INDEX_BITS+1:2]; tag [31:INDEX_BITS+2]. Storage: valid[] in flops; tag and data arrays read asynchronously.
- Hit: cpu_req & valid[index] & tag match & cacheable & state==IDLE & !flush -> cpu_ready=1 and cpu_rdata=data[index] in the same cycle. Increments hit_count.
- FSM states: IDLE, FILL, RESP.
- IDLE -> FILL: cpu_req and not a hit. Register fill_addr={cpu_addr[31:2],2'b00}. Increment miss_count. Clear settle=0.
- FILL:
  - Drive mem_req=1 and mem_addr=fill_addr; both are held constant for the whole state.
  - The crossbar registers the address, so data is valid only after the address has been presented for one full cycle with mem_ok=1.
  - Each cycle with mem_ok=0 forces settle<=0.
  - Each cycle with mem_ok=1 and settle==0 sets settle<=1.
  - A cycle with mem_ok=1 and settle==1 captures mem_din into fill_data and moves to RESP.
  - Minimum FILL length is 2 cycles.
- RESP:
  - cpu_ready=1, cpu_rdata=fill_data; next state IDLE.
  - If fill_addr is cacheable and no flush occurred during this miss, write data[idx], tag[idx] and valid[idx]=1 on this edge.
  - Minimum miss latency: 3 cycles from the request edge to cpu_ready.
- Non-cacheable address: always a miss and fetched normally; never allocated. Repeat fetches miss again.
- mem_req=0 and mem_addr=32'h0 in IDLE and RESP.
- Flush:
  - flush=1 clears every valid bit on the next edge.
  - While flush is high in IDLE, no hit is reported; a pending cpu_req is treated as a miss.
  - If flush is asserted during FILL or RESP, set a sticky no_alloc flag. The outstanding miss still completes and returns data but does not allocate. no_alloc clears on return to IDLE.
- cpu_req dropped mid-miss: not permitted; behaviour is undefined but must not hang. The FSM always completes to IDLE.
- Counters saturate at 32'hFFFF_FFFF. They are not cleared by flush.
- Reset: state=IDLE, all valid=0, cpu_ready=0, cpu_rdata=0, mem_req=0, mem_addr=0, fill_data=0, settle=0, no_alloc=0, hit_count=0, miss_count=0. Tag and data arrays are not reset. Reset in FILL or RESP aborts the fill with no allocation and no cpu_ready.

Test Plan:
1. Cold miss, then hit: cpu_addr=0x8000_0010, mem_ok=1, mem_din=0x2402_0005 on the second FILL cycle -> cpu_ready in cycle 3 with 0x2402_0005. Refetch same address -> cpu_ready same cycle, mem_req=0. hit_count=1, miss_count=1.
2. Stall during fill: mem_ok pattern in FILL 1,0,0,1,1 -> capture only on the 5th FILL cycle (settle resets on each 0). cpu_ready one cycle later with the value on mem_din at that 5th cycle.
3. Conflict eviction: fetch 0x8000_0004, then 0x8000_0104 (same index with INDEX_BITS=6) -> both miss. Refetch 0x8000_0004 -> misses again; miss_count=3.
4. Uncached: fetch 0xBFC0_0000 twice -> two misses, two fills, never a hit.
5. Flush: fill 0x8000_0020, pulse flush in IDLE, refetch -> miss. Assert flush during FILL of 0x8000_0030 -> data returned, then refetch misses.
6. Reset mid-FILL: rst for 1 cycle while in FILL -> mem_req=0 next cycle, no cpu_ready, all lines invalid, counters 0.
